bit_checker: RTL

- Receive-side counterpart of the transmit bit source.
- Consumes the demodulated bit stream from the QAM16 receive chain.
- Aligns the stream to the known 1024-bit pattern stored in the bit ROM, then counts received bits and bit errors for BER measurement.
- The ROM lives outside the block and is accessed through an address/data port with one cycle of read latency.

---
 rtl/bit_checker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bit_checker.sv
// rtl/bit_checker.sv - receive-side pattern aligner and BER bit/error counter
// Optional BIT_CHECKER_SAT_EN: counters saturate instead of wrapping.
module bit_checker #(
  parameter int ADDR_W   = 10,
  parameter int SYNC_LEN = 32,
  parameter int LOSS_THR = 64,
  parameter int CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              clr,
  output logic [ADDR_W-1:0] ref_addr,
  input  logic              ref_bit,
  output logic              locked,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_pulse,
  output logic              frame_done
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } state_t;

  localparam logic [8:0]      SYNC_V  = SYNC_LEN[8:0];
  localparam logic [ADDR_W:0] LOSS_V  = LOSS_THR[ADDR_W:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
  logic [7:0]        match_cnt_q, match_cnt_d;
  logic [ADDR_W:0]   win_err_q, win_err_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic              frame_done_q, frame_done_d;
  logic              locked_q, locked_d;

  logic              mism;
  logic              bit_inc;
  logic              err_inc;
  logic [8:0]        match_nxt;
  logic [ADDR_W:0]   win_total;

  assign mism = in_bit ^ ref_bit;

  always_comb begin
    state_d      = state_q;
    ref_addr_d   = ref_addr_q;
    match_cnt_d  = match_cnt_q;
    win_err_d    = win_err_q;
    bit_cnt_d    = bit_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_pulse_d  = 1'b0;
    frame_done_d = 1'b0;
    locked_d     = (state_q == LOCK);
    bit_inc      = 1'b0;
    err_inc      = 1'b0;
    match_nxt    = {1'b0, match_cnt_q} + 9'd1;
    win_total    = win_err_q + {{ADDR_W{1'b0}}, mism};

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (!mism) begin
            ref_addr_d = ref_addr_q + ADDR_W'(1);
            if (match_nxt >= SYNC_V) begin
              state_d     = LOCK;
              win_err_d   = '0;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_nxt[7:0];
            end
          end else begin
            // Skipping one extra ROM address slides the phase by one bit.
            ref_addr_d  = ref_addr_q + ADDR_W'(2);
            match_cnt_d = '0;
          end
        end
        LOCK: begin
          ref_addr_d  = ref_addr_q + ADDR_W'(1);
          bit_inc     = 1'b1;
          err_inc     = mism;
          err_pulse_d = mism;
          if (&ref_addr_q) begin
            frame_done_d = 1'b1;
            win_err_d    = '0;
            if (win_total > LOSS_V) begin
              state_d     = SEARCH;
              match_cnt_d = '0;
            end
          end else begin
            win_err_d = win_total;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

`ifdef BIT_CHECKER_SAT_EN
    // Errors freeze with the bit count so the ratio stays meaningful.
    if (bit_inc && (bit_cnt_q != CNT_MAX)) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (err_inc && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
`else
    bit_cnt_d = bit_cnt_q + CNT_W'(bit_inc);
    err_cnt_d = err_cnt_q + CNT_W'(err_inc);
`endif

    if (clr) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state_q      <= SEARCH;
      ref_addr_q   <= '0;
      match_cnt_q  <= '0;
      win_err_q    <= '0;
      bit_cnt_q    <= '0;
      err_cnt_q    <= '0;
      err_pulse_q  <= 1'b0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_addr_q   <= ref_addr_d;
      match_cnt_q  <= match_cnt_d;
      win_err_q    <= win_err_d;
      bit_cnt_q    <= bit_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_pulse_q  <= err_pulse_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
    end
  end

  assign ref_addr   = ref_addr_q;
  assign locked     = locked_q;
  assign bit_cnt    = bit_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_pulse  = err_pulse_q;
  assign frame_done = frame_done_q;

endmodule
